// File: rtl/mem_bus_arb.sv
// Two-master arbiter for a single-slave memory bus. There is one outstanding
// access at a time. The access completes on s_ack or ends with an error after TIMEOUT BUSY cycles.
module mem_bus_arb #(
   parameter int unsigned TIMEOUT = 16,
   parameter bit          M0_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [3:0]  m0_be,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic        m0_kill,
   output logic        m0_gnt,
   output logic        m0_done,
   output logic [31:0] m0_rdata,
   output logic        m0_err,

   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [3:0]  m1_be,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_done,
   output logic [31:0] m1_rdata,
   output logic        m1_err,

   output logic        s_req,
   output logic        s_we,
   output logic [3:0]  s_be,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   input  logic        s_ack
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;     // 0 = M0, 1 = M1
   logic        last_q, last_d;       // master served by the most recent grant
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        m0_done_q, m0_done_d;
   logic        m1_done_q, m1_done_d;
   logic        m0_err_q, m0_err_d;
   logic        m1_err_q, m1_err_d;
   logic [31:0] m0_rdata_q, m0_rdata_d;
   logic [31:0] m1_rdata_q, m1_rdata_d;

   logic        elig0, elig1, pick1;
   logic        busy;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      we_d       = we_q;
      be_d       = be_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      m0_done_d  = 1'b0;
      m1_done_d  = 1'b0;
      m0_err_d   = 1'b0;
      m1_err_d   = 1'b0;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
      m0_gnt     = 1'b0;
      m1_gnt     = 1'b0;
      pick1      = 1'b0;
      elig0      = m0_req & ~m0_kill;
      elig1      = m1_req;

      case (state_q)
         IDLE: begin
            // Grants are combinational, so they are also masked while reset is held.
            if (reset && (elig0 || elig1)) begin
               if (elig0 && elig1) begin
                  pick1 = M0_PRIO ? 1'b0 : ~last_q;
               end else begin
                  pick1 = elig1;
               end
               m0_gnt  = ~pick1;
               m1_gnt  = pick1;
               owner_d = pick1;
               last_d  = pick1;
               we_d    = pick1 ? m1_we    : m0_we;
               be_d    = pick1 ? m1_be    : m0_be;
               addr_d  = pick1 ? m1_addr  : m0_addr;
               wdata_d = pick1 ? m1_wdata : m0_wdata;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (s_ack) begin
               m0_done_d = ~owner_q;
               m1_done_d = owner_q;
               if (!we_q) begin
                  if (owner_q) m1_rdata_d = s_rdata;
                  else         m0_rdata_d = s_rdata;
               end
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               m0_done_d = ~owner_q;
               m1_done_d = owner_q;
               m0_err_d  = ~owner_q;
               m1_err_d  = owner_q;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         we_q       <= 1'b0;
         be_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         m0_done_q  <= 1'b0;
         m1_done_q  <= 1'b0;
         m0_err_q   <= 1'b0;
         m1_err_q   <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         we_q       <= we_d;
         be_q       <= be_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         m0_done_q  <= m0_done_d;
         m1_done_q  <= m1_done_d;
         m0_err_q   <= m0_err_d;
         m1_err_q   <= m1_err_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
      end
   end

   // Slave payload is forced to zero whenever no access is in flight.
   assign busy     = (state_q == BUSY);
   assign s_req    = busy;
   assign s_we     = busy & we_q;
   assign s_be     = busy ? be_q    : 4'd0;
   assign s_addr   = busy ? addr_q  : 32'd0;
   assign s_wdata  = busy ? wdata_q : 32'd0;

   assign m0_done  = m0_done_q;
   assign m1_done  = m1_done_q;
   assign m0_err   = m0_err_q;
   assign m1_err   = m1_err_q;
   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;

endmodule

// File: doc/mem_bus_arb.md
MEM_BUS_ARB -- requirements
Module: mem_bus_arb

Parameters
REQ-001 TIMEOUT, 16, BUSY cycles without s_ack before error completion (range 2..255).
REQ-002 M0_PRIO, 0; 1 = M0 fixed priority, 0 = round-robin.

Interface
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mN_req (N=0,1)  input  1  master N requests one access; held until mN_gnt.
REQ-006 mN_we  input  1  1 = write, 0 = read.
REQ-007 mN_be  input  4  byte enables.
REQ-008 mN_addr  input  32  byte address.
REQ-009 mN_wdata  input  32  write data, already lane-replicated by the master.
REQ-010 m0_kill  input  1  CPU exception; blocks M0 eligibility while high.
REQ-011 mN_gnt  output  1  combinational; request accepted at this edge.
REQ-012 mN_done  output  1  registered one-cycle completion pulse.
REQ-013 mN_rdata  output  32  registered read data of the last completed read by N.
REQ-014 mN_err  output  1  valid with mN_done; 1 = timed out.
REQ-015 s_req  output  1  slave access strobe, high for the whole BUSY state.
REQ-016 s_we, s_be[3:0], s_addr[31:0], s_wdata[31:0]  output  latched payload; all zero outside BUSY.
REQ-017 s_rdata  input  32  slave read data, sampled with s_ack.
REQ-018 s_ack  input  1  slave completion; ignored outside BUSY.

Function
REQ-019 The block SHALL use two states: IDLE and BUSY.
REQ-020 In IDLE, M0 SHALL be eligible iff m0_req & ~m0_kill; M1 SHALL be eligible iff m1_req.
REQ-021 If any master is eligible, the block SHALL select a winner, assert its gnt in that cycle, latch we/be/addr/wdata and the owner at the edge, and enter BUSY.
REQ-022 With M0_PRIO=1, M0 SHALL always win a conflict; with 0, the master not served last SHALL win.
REQ-023 The last-served register SHALL update on every grant.
REQ-024 At most one gnt SHALL be high in any cycle; no gnt SHALL be high in BUSY.
REQ-025 In BUSY, s_req SHALL be 1 and the payload SHALL be stable until completion.
REQ-026 s_ack=1 in BUSY SHALL complete at the edge: owner done=1 and err=0 for the next cycle, and state returns to IDLE.
REQ-027 On a read completion, owner rdata SHALL load s_rdata.
REQ-028 Write completions and errors SHALL leave rdata unchanged.
REQ-029 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without s_ack.
REQ-030 When the counter reaches TIMEOUT-1 with s_ack=0, the block SHALL complete with err=1.
REQ-031 If s_ack coincides with the timeout cycle, it SHALL be treated as a normal completion (err=0).
REQ-032 Minimum latency SHALL be: gnt at cycle 0, s_req at cycle 1, s_ack at cycle 1, done at cycle 2.
REQ-033 A new grant SHALL be allowed in the same cycle as the previous done pulse.
REQ-034 m0_kill SHALL have no effect on a transaction already in BUSY.
REQ-035 A request that drops before gnt SHALL be silently discarded.

Reset
REQ-036 While reset=0, the block SHALL force: state IDLE, all outputs 0, rdata regs 0, counter 0, last-served=M1 (so M0 wins the first conflict).
REQ-037 Reset asserted during BUSY SHALL abort immediately: s_req drops asynchronously and no done/err is issued.

Verification
REQ-038 M0 read, addr 0x0000_1004, s_ack on first BUSY cycle, s_rdata 0xDEAD_BEEF -> m0_gnt cycle 0, s_req cycle 1, m0_done=1/m0_err=0 cycle 2, m0_rdata=0xDEAD_BEEF.
REQ-039 M0_PRIO=0, both request continuously, s_ack always 1 -> grants alternate M0,M1,M0,M1 starting with M0, one grant every 2 cycles.
REQ-040 M0_PRIO=1, both request continuously -> M0 granted every time; M1 never granted.
REQ-041 TIMEOUT=16, M1 write, s_ack held 0 -> m1_done=1/m1_err=1 after 16 BUSY cycles, m1_rdata unchanged, s_* zero next cycle.
REQ-042 m0_kill=1 with m0_req=1 and m1_req=1 in IDLE -> m1_gnt=1, m0_gnt=0; after kill deasserts, M0 is granted next.
REQ-043 Reset pulled low on the 3rd BUSY cycle -> s_req=0 same cycle, no done pulse, first request after release granted normally.
